// File: rtl/pipe_hazard_unit.sv
// Hazard detection, ID operand forwarding and interrupt sequencing for the pipelined CPU.
// A shelf of in-flight register writes (EX, MEM1..MEMn, WB) feeds forwarding and the RF write port.
module pipe_hazard_unit #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wr,
  input  logic          id_load,
  input  logic [31:0]   id_pc,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  input  logic [DW-1:0] alu_res,
  input  logic [DW-1:0] ld_res,
  input  logic          id_jump,
  input  logic          ex_br_taken,
  input  logic          irq,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          stall,
  output logic          flush_ifid,
  output logic          flush_idex,
  output logic          irq_take,
  output logic [31:0]   epc,
  output logic          wb_wr,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  localparam int unsigned D   = LOAD_LAT + 2;
  localparam int unsigned PCW = 32;

  typedef struct packed {
    logic          v;
    logic          ld;
    logic          rdy;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } shelf_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TAKE = 2'd2
  } irq_state_e;

  shelf_t     shelf_q [D];
  shelf_t     shelf_d [D];
  irq_state_e irq_state_q;
  logic       irq_take_q;
  logic [PCW-1:0] epc_q;
  logic       br_q;

  logic [AW-1:0] src_addr [2];
  logic          src_used [2];
  logic [DW-1:0] src_rf   [2];
  logic [DW-1:0] src_val  [2];
  logic          src_hz   [2];

  logic issue;
  logic irq_safe;

  always_comb begin
    src_addr[0] = id_rs;
    src_addr[1] = id_rt;
    src_used[0] = id_rs_used;
    src_used[1] = id_rt_used;
    src_rf[0]   = rf_a;
    src_rf[1]   = rf_b;
  end

  // Youngest (lowest index) valid match decides forward value or load-use hazard.
  always_comb begin : operand_lookup
    logic hit;
    hit = 1'b0;
    for (int unsigned s = 0; s < 2; s++) begin
      hit        = 1'b0;
      src_val[s] = src_rf[s];
      src_hz[s]  = 1'b0;
      for (int unsigned k = 0; k < D; k++) begin
        if (!hit && shelf_q[k].v && (shelf_q[k].rd == src_addr[s])) begin
          hit = 1'b1;
          if (k == 0 && !shelf_q[k].ld) begin
            src_val[s] = alu_res;
          end else if (k == LOAD_LAT && shelf_q[k].ld) begin
            src_val[s] = ld_res;
          end else if (shelf_q[k].rdy) begin
            src_val[s] = shelf_q[k].data;
          end else begin
            src_hz[s] = 1'b1;
          end
        end
      end
      if (!src_used[s]) begin
        src_val[s] = src_rf[s];
        src_hz[s]  = 1'b0;
      end
      if (src_addr[s] == '0) begin
        src_val[s] = '0;
        src_hz[s]  = 1'b0;
      end
    end
  end

  always_comb begin
    op_a       = src_val[0];
    op_b       = src_val[1];
    flush_idex = ex_br_taken;
    stall      = id_valid & (src_hz[0] | src_hz[1]) & ~ex_br_taken;
    flush_ifid = ex_br_taken | id_jump | irq_take_q;
    issue      = id_valid & ~stall & ~flush_idex & ~irq_take_q;
    irq_safe   = id_valid & ~stall & ~ex_br_taken & ~br_q;
  end

  // Shift the shelf; results are captured as they leave the stage that produces them.
  always_comb begin : shelf_next
    shelf_d[0]    = '0;
    shelf_d[0].v  = issue & id_wr & (id_rd != '0);
    shelf_d[0].ld = issue & id_load;
    shelf_d[0].rd = id_rd;
    for (int unsigned k = 1; k < D; k++) begin
      shelf_d[k] = shelf_q[k-1];
      if (k == 1 && !shelf_q[k-1].ld) begin
        shelf_d[k].data = alu_res;
        shelf_d[k].rdy  = 1'b1;
      end
      if (k == LOAD_LAT + 1 && shelf_q[k-1].ld) begin
        shelf_d[k].data = ld_res;
        shelf_d[k].rdy  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < D; k++) begin
        shelf_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < D; k++) begin
        shelf_q[k] <= shelf_d[k];
      end
    end
  end

  // Interrupt entry is deferred until ID holds an instruction that will not be squashed or held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_state_q <= IDLE;
      irq_take_q  <= 1'b0;
      epc_q       <= '0;
      br_q        <= 1'b0;
    end else begin
      br_q <= ex_br_taken;
      case (irq_state_q)
        IDLE: begin
          irq_take_q <= 1'b0;
          if (irq) begin
            irq_state_q <= PEND;
          end
        end
        PEND: begin
          if (irq_safe) begin
            irq_state_q <= TAKE;
            irq_take_q  <= 1'b1;
          end
        end
        TAKE: begin
          irq_state_q <= IDLE;
          irq_take_q  <= 1'b0;
          epc_q       <= id_pc;
        end
        default: begin
          irq_state_q <= IDLE;
          irq_take_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    irq_take = irq_take_q;
    epc      = epc_q;
    wb_wr    = shelf_q[D-1].v;
    wb_rd    = shelf_q[D-1].rd;
    wb_data  = shelf_q[D-1].data;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and interrupt-sequencing unit for the pipelined CPU. It sits beside the ID stage and keeps a result shelf of in-flight register writes, one entry per post-ID stage. Each cycle it supplies forwarded ID operands, generates stall and flush controls, and defers interrupt entry to a safe instruction boundary. It supersedes the ad-hoc load-use check: the load latency is configurable and `$0` is handled correctly.

## Interface
Parameters
- `DW`, 32, datapath width.
- `AW`, 5, register address width.
- `LOAD_LAT`, 1, number of MEM cycles before load data is valid. Legal values 1..3.
- Derived: `D = LOAD_LAT+2`, the number of shelf entries (EX, MEM1..MEM`LOAD_LAT`, WB).

Ports
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in `AW`: source register addresses in ID.
- `id_rs_used`, `id_rt_used` in 1: the corresponding source is actually read.
- `id_rd` in `AW`: destination register of the ID instruction.
- `id_wr` in 1: the ID instruction writes `id_rd`.
- `id_load` in 1: the ID instruction is a load.
- `id_pc` in 32: PC of the ID instruction.
- `rf_a`, `rf_b` in `DW`: register-file read data.
- `alu_res` in `DW`: EX-stage result for shelf entry 0.
- `ld_res` in `DW`: load data for shelf entry `LOAD_LAT`.
- `id_jump` in 1: a J/JR is resolved in ID.
- `ex_br_taken` in 1: a branch is resolved taken in EX.
- `irq` in 1: level interrupt request.
- `op_a`, `op_b` out `DW`: forwarded operands to the ID/EX register.
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX.
- `flush_ifid` out 1: squash IF/ID.
- `flush_idex` out 1: squash ID/EX.
- `irq_take` out 1: one-cycle pulse; the ID instruction is replaced by the trap.
- `epc` out 32: return address for the trap.
- `wb_wr` out 1, `wb_rd` out `AW`, `wb_data` out `DW`: the shelf tail, driving the register-file write port.

## Operation
Shelf entries
- Each entry holds `{v, ld, rdy, rd, data}`. Entry 0 is EX; entry `D-1` is WB.
- The shelf shifts every cycle with no back-pressure: entry k moves to entry k+1.

Issue into entry 0
- Condition for a valid entry: `id_valid & ~stall & ~flush_idex & ~irq_take`.
- Contents on issue: `v = id_wr & (id_rd != 0)`, `ld = id_load`, `rdy = 0`.
- Otherwise entry 0 becomes a bubble with `v = 0`.

Data capture on shift
- Non-load leaving entry 0: `data <= alu_res`, `rdy <= 1`.
- Load leaving entry `LOAD_LAT`: `data <= ld_res`, `rdy <= 1`.

Operand lookup (done separately for rs and rt)
- The youngest matching entry with `v` set wins. A match requires address equality and a nonzero address.
- Matching entry is non-load entry 0: forward `alu_res`.
- Matching entry is load entry `LOAD_LAT`: forward `ld_res`.
- Matching entry has `rdy` set: forward its `data`.
- Matching entry is a load at an index below `LOAD_LAT`: hazard.
- No match, or an unused source: pass the register-file value (`rf_a` / `rf_b`).
- `$0` always reads as 0. This applies regardless of `rf` contents.

Control outputs
- `stall = id_valid & (hazard_rs | hazard_rt) & ~flush_ifid_br`.
- `flush_idex = ex_br_taken`.
- `flush_ifid = ex_br_taken | id_jump | irq_take`.
- A taken branch overrides a stall.

Interrupt FSM
- States:
  - `IDLE`: goes to `PEND` when `irq` is high.
  - `PEND`: goes to `TAKE` when the ID instruction is safe.
  - `TAKE`: lasts one cycle, then returns to `IDLE`. It asserts `irq_take` and latches `epc <= id_pc`.
- An ID instruction is safe when all of these hold: `id_valid`, `~stall`, `~ex_br_taken`, and no branch was taken in the previous cycle.
- `irq` deasserting while in `PEND` does not cancel the pending interrupt.
- `irq` held high returns the FSM to `PEND` after `IDLE`. Software masking is outside this unit.

## Timing
Reset values (`reset` low, asynchronous)
- All shelf `v = 0`, FSM = `IDLE`.
- `stall`, `flush_*`, `irq_take`, `wb_wr` = 0; `epc` = 0.
- `op_a` / `op_b` equal the combinational passthrough of `rf_a` / `rf_b`.

Latency
- Operands, stall and flushes are combinational from the current inputs and shelf state.
- Shelf and FSM update on the rising edge of `clk`.
- `irq_take` asserts no earlier than 2 cycles after `irq` rises: rise, then `PEND`, then `TAKE`.

Hazard penalties
- ALU to dependent instruction: 0 stall cycles at any distance.
- Load to dependent instruction: exactly `LOAD_LAT` stall cycles when the dependent instruction immediately follows the load. The penalty shrinks by one for each instruction of separation.

Boundary and simultaneous events
- Two entries matching the same address: the youngest entry wins.
- WB entry matching while the register file is written in the same cycle: the shelf value wins.
- Branch taken while stalling: the flush wins. The bubble and the squash must not double-issue.
- `irq` arriving during a stall or branch: the interrupt waits in `PEND`.
- Reset asserted mid-stall or in `PEND`: all state clears immediately and no `irq_take` is emitted.

## Test plan
- ALU back-to-back forwarding: `add $3,$1,$2` with `alu_res=0x11` in EX, next instruction reads `$3` → `op_a = 0x11`, `stall = 0`.
- Load-use, `LOAD_LAT=1`: `lw $4`, then an instruction using `$4`; `ld_res = 0xDEAD_BEEF` arrives in MEM1 → exactly 1 stall cycle, then `op_b = 0xDEADBEEF`.
- Load-use, `LOAD_LAT=3`: same sequence → exactly 3 stall cycles; with one independent instruction between load and use → 2 stall cycles.
- `$0` write and read: `id_rd = 0`, `id_wr = 1`, then a read of `$0` with `rf_a = 0x5` → `op_a = 0`, `wb_wr = 0`.
- Interrupt deferral: `irq` pulses in the same cycle as `ex_br_taken` → `irq_take` suppressed that cycle and the next; it fires on the first safe ID instruction with `epc = id_pc`, and fires once only.
- Reset mid-operation: `reset` driven low during a load-use stall and `PEND` → `stall = 0`, `irq_take = 0` immediately; after release, the shelf is empty and no spurious forwarding occurs.
